// File: rtl/io_bridge_pkg.sv
// Shared decode constants and UART transmitter state encoding for the CPU I/O bridge.
package io_bridge_pkg;

    localparam logic [1:0] IO_BASE_HI  = 2'b11;
    localparam logic [2:0] IO_TX_OFF   = 3'd0;
    localparam logic [2:0] IO_HALT_OFF = 3'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/cpu_io_bridge_uart_tx.sv
// 8N1 UART serializer: one start bit, eight data bits LSB first, one stop bit,
// each held BAUD_DIV clocks. The line output is registered and idles high.
module uart_tx
    import io_bridge_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    // Handshake: a byte moves on any clock where valid and ready are both high;
    // valid must not depend on ready, and ready is high only while idle.
    uart_tx_state_t state, state_nx;
    logic [CW-1:0]  baud_cnt, baud_cnt_nx;
    logic [2:0]     bit_idx, bit_idx_nx;
    logic [7:0]     shreg, shreg_nx;
    logic           txd_nx;
    logic           baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_idx  <= bit_idx_nx;
            shreg    <= shreg_nx;
            txd      <= txd_nx;
        end
    end

    // The line level is a registered copy of what the current state drives.
    always_comb begin
        state_nx    = state;
        baud_cnt_nx = baud_cnt + 1'b1;
        bit_idx_nx  = bit_idx;
        shreg_nx    = shreg;
        ready       = 1'b0;
        txd_nx      = 1'b1;
        case (state)
            TX_IDLE: begin
                ready       = 1'b1;
                baud_cnt_nx = '0;
                if (valid) begin
                    shreg_nx = data;
                    state_nx = TX_START;
                end
            end
            TX_START: begin
                txd_nx = 1'b0;
                if (baud_done) begin
                    state_nx    = TX_DATA;
                    baud_cnt_nx = '0;
                    bit_idx_nx  = '0;
                end
            end
            TX_DATA: begin
                txd_nx = shreg[bit_idx];
                if (baud_done) begin
                    baud_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = TX_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                txd_nx = 1'b1;
                if (baud_done) begin
                    state_nx    = TX_IDLE;
                    baud_cnt_nx = '0;
                end
            end
            default: begin
                state_nx    = TX_IDLE;
                baud_cnt_nx = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// Byte-bus bridge between the CPU memory port, the 128 KiB RAM and a UART TX FIFO,
// with a sticky halt flag and a one-cycle read path matching the RAM latency.
module cpu_io_bridge
    import io_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 434
) (
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic        uart_txd,
    output logic        halt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_COUNT   = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] ALMOST_COUNT = PW'(FIFO_DEPTH - 1);

    logic          io_sel;
    logic          tx_wr;
    logic          halt_wr;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          overflow;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          io_sel_q;
    logic [7:0]    io_rdata_q;
    logic          unused_addr;

    assign io_sel    = (cpu_a[17:16] == IO_BASE_HI);
    assign ram_a     = cpu_a[16:0];
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_wr & ~io_sel;
    assign tx_wr     = cpu_wr & io_sel & (cpu_a[2:0] == IO_TX_OFF);
    assign halt_wr   = cpu_wr & io_sel & (cpu_a[2:0] == IO_HALT_OFF);

    assign unused_addr = ^cpu_a[31:18];

    // Pointers carry an extra wrap bit so a full FIFO is distinguishable from empty.
    assign count      = wp - rp;
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_mem[rp[AW-1:0]];
    assign pop        = tx_valid & tx_ready;
    // A concurrent pop frees the slot, so a write to a full FIFO still lands.
    assign push       = tx_wr & (~fifo_full | pop);

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wp[AW-1:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            wp             <= '0;
            rp             <= '0;
            overflow       <= 1'b0;
            halt           <= 1'b0;
            io_buffer_full <= 1'b0;
            io_sel_q       <= 1'b0;
            io_rdata_q     <= 8'h00;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (tx_wr && !push) begin
                overflow <= 1'b1;
            end
            if (halt_wr) begin
                halt <= 1'b1;
            end
            io_buffer_full <= (count >= ALMOST_COUNT);
            io_sel_q       <= io_sel;
            io_rdata_q     <= (io_sel && (cpu_a[2:0] == IO_HALT_OFF))
                              ? {6'b0, overflow, fifo_full} : 8'h00;
        end
    end

    assign cpu_rdata = io_sel_q ? io_rdata_q : ram_rdata;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk_in  (clk_in),
        .rstn_in (rstn_in),
        .valid   (tx_valid),
        .data    (tx_data),
        .ready   (tx_ready),
        .txd     (uart_txd)
    );

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge with a RAM model, a read-data scoreboard and a UART line decoder.
module tb_cpu_io_bridge;

    localparam int FIFO_DEPTH = 8;
    localparam int BAUD_DIV   = 4;

    logic        clk_in = 1'b0;
    logic        rstn_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_wdata;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        uart_txd;
    logic        halt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    logic [7:0] ram_mem [0:131071] = '{default: 8'hA5};

    cpu_io_bridge #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_DIV   (BAUD_DIV)
    ) dut (
        .clk_in         (clk_in),
        .rstn_in        (rstn_in),
        .cpu_a          (cpu_a),
        .cpu_wdata      (cpu_wdata),
        .cpu_wr         (cpu_wr),
        .cpu_rdata      (cpu_rdata),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_rdata      (ram_rdata),
        .uart_txd       (uart_txd),
        .halt           (halt)
    );

    // clock and RAM model
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_wdata;
        ram_rdata <= ram_mem[ram_a];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic io_write(input logic [31:0] a, input logic [7:0] d);
        cpu_a     = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        @(negedge clk_in);
        cpu_wr    = 1'b0;
        cpu_a     = 32'h0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        cpu_a  = a;
        cpu_wr = 1'b0;
        exp_q.push_back(exp);
        @(negedge clk_in);
        e = exp_q.pop_front();
        check(tag, cpu_rdata, e);
        cpu_a = 32'h0;
    endtask

    // UART line decoder: samples mid-bit, abandons a frame cut by reset
    always begin : uart_mon
        logic       ok;
        logic       st;
        logic       sp;
        logic [7:0] b;
        logic [7:0] e;
        @(negedge clk_in);
        if (rstn_in === 1'b1 && uart_txd === 1'b0) begin
            ok = 1'b1;
            st = 1'bx;
            sp = 1'bx;
            b  = 8'hxx;
            for (int n = 1; n <= 38 && ok; n++) begin
                @(negedge clk_in);
                if (rstn_in !== 1'b1) ok = 1'b0;
                else if (n == 2) st = uart_txd;
                else if (n >= 6 && n <= 34 && (n % 4) == 2) b[(n - 6) / 4] = uart_txd;
                else if (n == 38) sp = uart_txd;
            end
            if (ok) begin
                check("uart_start_bit", st, 1'b0);
                check("uart_stop_bit", sp, 1'b1);
                check("uart_frame_expected", tx_q.size() > 0, 1'b1);
                if (tx_q.size() > 0) begin
                    e = tx_q.pop_front();
                    check("uart_byte", b, e);
                end
            end
        end
    end

    initial begin
        logic [9:0] frame;
        rstn_in   = 1'b0;
        cpu_a     = 32'h0;
        cpu_wdata = 8'h00;
        cpu_wr    = 1'b0;

        // reset state
        repeat (3) @(negedge clk_in);
        check("rst_txd", uart_txd, 1'b1);
        check("rst_halt", halt, 1'b0);
        check("rst_ibf", io_buffer_full, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_rdata_from_ram", cpu_rdata, 8'hA5);
        rstn_in = 1'b1;
        @(negedge clk_in);

        // RAM pass-through
        cpu_a = 32'h0001_1234; cpu_a = 32'h0000_1234; cpu_wdata = 8'h5A; cpu_wr = 1'b1;
        #1;
        check("ram_we_pulse", ram_we, 1'b1);
        check("ram_a", ram_a, 17'h01234);
        check("ram_wdata", ram_wdata, 8'h5A);
        @(negedge clk_in);
        cpu_wr = 1'b0;
        #1;
        check("ram_we_low", ram_we, 1'b0);
        cpu_read(32'h0000_1234, 8'h5A, "ram_read");
        cpu_read(32'h4000_1234, 8'h5A, "ram_read_alias");
        cpu_read(32'h0000_0040, 8'hA5, "ram_read_unwritten");
        cpu_read(32'h0003_0004, 8'h00, "io_status_idle");

        // halt flag
        cpu_a = 32'h0003_0004; cpu_wdata = 8'h77; cpu_wr = 1'b1;
        #1;
        check("io_write_no_ram_we", ram_we, 1'b0);
        check("halt_before_edge", halt, 1'b0);
        @(negedge clk_in);
        cpu_wr = 1'b0;
        check("halt_set", halt, 1'b1);
        io_write(32'h0000_2000, 8'h33);
        cpu_read(32'h0000_2000, 8'h33, "ram_read_2");
        check("halt_sticky", halt, 1'b1);

        // single TX byte, cycle-exact line waveform
        tx_q.push_back(8'h41);
        io_write(32'h0003_0000, 8'h41);
        check("tx_idle_edge_n", uart_txd, 1'b1);
        @(negedge clk_in);
        check("tx_idle_edge_n1", uart_txd, 1'b1);
        frame = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 10 * BAUD_DIV; k++) begin
            @(negedge clk_in);
            check("tx_wave", uart_txd, frame[k / BAUD_DIV]);
        end
        @(negedge clk_in);
        check("tx_after_frame", uart_txd, 1'b1);

        // fill the FIFO, overflow on the 10th write
        for (int k = 1; k <= 9; k++) begin
            tx_q.push_back(8'(k * 16));
            io_write(32'h0003_0000, 8'(k * 16));
            check("fill_ibf", io_buffer_full, k >= 9);
        end
        io_write(32'h0003_0000, 8'hA0);
        check("overflow_ibf", io_buffer_full, 1'b1);
        cpu_read(32'h0003_0004, 8'h03, "status_overflow_full");
        cpu_read(32'h0003_0000, 8'h00, "status_other_addr");
        check("halt_still_set", halt, 1'b1);

        // reset during the data bits of the second frame
        repeat (37) @(negedge clk_in);
        check("mid_frame_data_bit", uart_txd, 1'b0);
        rstn_in = 1'b0;
        #1;
        check("rst_async_txd", uart_txd, 1'b1);
        tx_q.delete();
        repeat (2) @(negedge clk_in);
        check("rst_mid_halt", halt, 1'b0);
        rstn_in = 1'b1;
        repeat (5) @(negedge clk_in);
        check("post_rst_ibf", io_buffer_full, 1'b0);
        check("post_rst_halt", halt, 1'b0);
        cpu_read(32'h0003_0004, 8'h00, "post_rst_status");

        // simultaneous push and pop with the FIFO full
        for (int k = 1; k <= 9; k++) begin
            tx_q.push_back(8'(k));
            io_write(32'h0003_0000, 8'(k));
        end
        repeat (33) @(negedge clk_in);
        tx_q.push_back(8'h0A);
        io_write(32'h0003_0000, 8'h0A);
        check("push_pop_ibf", io_buffer_full, 1'b1);
        cpu_read(32'h0003_0004, 8'h01, "push_pop_no_overflow");

        // drain and confirm order on the line
        for (int i = 0; i < 1000 && tx_q.size() != 0; i++) @(negedge clk_in);
        check("drain_complete", tx_q.size(), 0);
        repeat (BAUD_DIV + 2) @(negedge clk_in);
        check("drain_txd_idle", uart_txd, 1'b1);
        check("drain_ibf", io_buffer_full, 1'b0);
        cpu_read(32'h0003_0004, 8'h00, "drain_status");
        check("read_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_io_bridge.md
# cpu_io_bridge

Byte-bus bridge directly downstream of the `cpu` top's memory port. It decodes `mem_a`/`mem_dout`/`mem_wr`, passes RAM traffic through to the 128 KiB RAM, and absorbs memory-mapped I/O writes into a TX FIFO drained by an 8N1 UART serializer. It returns read data with the RAM's one-cycle latency, generates `io_buffer_full` back to the CPU, and latches a program-halt flag.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, at least 4.
- `BAUD_DIV`, 434: clock cycles per UART bit; at least 2.
- `clk_in`  in  1  system clock.
- Reset is asynchronous and active-low: `rstn_in`  in  1.
- `cpu_a`  in  32  CPU address (`mem_a`).
- `cpu_wdata`  in  8  CPU write byte (`mem_dout`).
- `cpu_wr`  in  1  1 = write, 0 = read.
- `cpu_rdata`  out  8  read byte to the CPU (`mem_din`).
- `io_buffer_full`  out  1  to the CPU; the CPU must not issue I/O writes while this is high.
- `ram_a`  out  17  RAM address.
- `ram_wdata`  out  8  RAM write byte.
- `ram_we`  out  1  RAM write enable.
- `ram_rdata`  in  8  RAM read byte; valid one cycle after its address.
- `uart_txd`  out  1  serial line; idles high.
- `halt`  out  1  sticky program-end flag.

## Operation
- **Decode.** `io_sel = (cpu_a[17:16] == 2'b11)`. This is combinational.
  - `ram_a = cpu_a[16:0]` and `ram_wdata = cpu_wdata`.
  - `ram_we = cpu_wr & ~io_sel`.
- **I/O writes** (`cpu_wr & io_sel`):
  - `cpu_a[2:0] == 0` (0x30000): push `cpu_wdata` into the FIFO. If the FIFO is full, drop the byte and set sticky `overflow`.
  - `cpu_a[2:0] == 4` (0x30004): set `halt`. It stays 1 until reset.
  - Any other I/O address: ignored.
- **Reads.** The bridge registers `io_sel_q` and `io_rdata_q` every cycle.
  - `cpu_rdata = io_sel_q ? io_rdata_q : ram_rdata`.
  - `io_rdata_q` is `{6'b0, overflow, fifo_full}` when the read address was 0x30004; otherwise 8'h00.
- **FIFO.**
  - Binary read and write pointers, each one bit wider than the index.
  - `count = wp - rp`; full when `count == FIFO_DEPTH`.
  - Pointers wrap naturally.
  - Push and pop in the same cycle leave `count` unchanged and are both legal, even when the FIFO is full (the pop frees the slot first).
- **io_buffer_full** = `count >= FIFO_DEPTH-1`, driven from a register. The one slot of margin covers an I/O write already in flight when the flag rises.
- **UART TX FSM**, states IDLE, START, DATA, STOP:
  - IDLE: `txd = 1`. If the FIFO is non-empty, pop into `shreg` and go to START.
  - START: `txd = 0` for `BAUD_DIV` cycles, then DATA with `bit_idx = 0`.
  - DATA: `txd = shreg[bit_idx]`, LSB first, each bit held `BAUD_DIV` cycles. After bit 7, go to STOP.
  - STOP: `txd = 1` for `BAUD_DIV` cycles, then IDLE.
  - The baud counter is `$clog2(BAUD_DIV)` bits and reloads to 0 on every state change.

## Timing
- **Reset values:** `cpu_rdata = ram_rdata` (because `io_sel_q = 0`), `io_buffer_full = 0`, `uart_txd = 1`, `halt = 0`, `overflow = 0`, FIFO empty, FSM in IDLE.
- **Reset mid-frame:** asserting reset during a frame aborts it; `txd` returns to 1 asynchronously.
- **RAM path:** `ram_a`/`ram_we` have zero latency; read data has 1-cycle latency, identical for RAM and I/O.
- **I/O write to serial line:** push at edge N, pop in IDLE at edge N+1, start bit begins after edge N+2.
- **Frame length:** `10*BAUD_DIV` cycles.
- **Back-to-back bytes:** one IDLE cycle (line high) between frames.
- **Flag latency:** `halt` rises one cycle after its write edge. `io_buffer_full` follows `count` with one cycle of register delay.

## Structure
- Shared package `io_bridge_pkg`:
  - address constants `IO_BASE_HI = 2'b11`, `IO_TX_OFF = 3'd0`, `IO_HALT_OFF = 3'd4`;
  - the `uart_tx_state_t` enum.
- One sub-module, `uart_tx`, containing the FSM, baud counter and shift register. Interface: `clk_in`, `rstn_in`, `valid`, `data[7:0]`, `ready`, `txd`. It pops when `valid & ready`, and `ready` is high only in IDLE.
- The FIFO is inline in `cpu_io_bridge`.

## Test plan
All scenarios use `FIFO_DEPTH = 8`, `BAUD_DIV = 4`.
- **RAM pass-through:** write 0x5A to 0x01234, then read 0x01234 → `ram_we` pulses with `ram_a = 17'h01234`; `cpu_rdata = 0x5A` one cycle after the read address.
- **Single TX byte:** write 0x41 to 0x30000 → after the start bit, `uart_txd` shows 0, then 1,0,0,0,0,0,1,0, then 1. Each bit lasts 4 cycles; the frame is 40 cycles.
- **Fill the FIFO:** 9 back-to-back writes to 0x30000 while the UART is idle → `io_buffer_full` is high once `count` reaches 7. The 9th byte lands because of the concurrent pop. A 10th immediate write is dropped and a read of 0x30004 returns 0x03.
- **Halt:** write any byte to 0x30004 → `halt = 1` from the next cycle and stays high through later traffic.
- **Reset mid-frame:** pull `rstn_in` low during the DATA state → `uart_txd = 1` immediately; after release `io_buffer_full = 0` and a read of 0x30004 returns 0x00.
- **Simultaneous push and pop at count 8:** the UART pops while the CPU writes → `count` stays 8, no overflow, and byte order on the line is preserved.
